// File: rtl/fifo_rd_sched_pkg.sv
// Shared definitions for the FIFO read-side scheduler and its round-robin helper.
// Holds the scheduler state encoding and the width helpers used for parameter sizing.
package fifo_rd_sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// Combinational round-robin selector: returns the first requester after 'last', wrapping.
// Shared by the read-side scheduler and the write-side arbiter.
module rr_pick
    import fifo_rd_sched_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx     = '0;
        gnt_idx = '0;
        any     = |req;
        // Walk from the farthest offset to the nearest so the closest requester wins.
        for (int off = NUM_CH; off >= 1; off--) begin
            idx = CH_W'((int'(last) + off) % NUM_CH);
            if (req[idx]) gnt_idx = idx;
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler draining NUM_CH dual-clock FIFOs in round-robin bursts into one
// valid/ready stream, tagged with source channel and first-of-grant marker.
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    parameter  int BURST  = 4,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic                    rclk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       ch_empty,
    input  logic [NUM_CH*WIDTH-1:0] ch_dout,
    output logic [NUM_CH-1:0]       ch_rd_en,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]         m_ch,
    output logic                    m_sof,
    output logic                    busy
);

    localparam int CNT_W = clog2(BURST + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
        logic             sof;
    } entry_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  grant, grant_nxt;     // current grant, doubles as last_grant
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sof_pend, sof_pend_nxt;

    logic             if_valid;
    logic [CH_W-1:0]  if_ch;
    logic             if_sof;

    entry_t           buf_q [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       occ;

    logic [NUM_CH-1:0] cand;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic              grant_empty, issue, push, pop;
    logic [2:0]        credit;
    logic [WIDTH-1:0]  dout_sel;

    assign cand = ch_enable & ~ch_empty;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .req     (cand),
        .last    (grant),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign pop         = m_valid & m_ready;
    assign push        = if_valid;
    assign grant_empty = ch_empty[grant];
    // Buffered plus in-flight words may not exceed the two slots; a word leaving now frees one.
    assign credit      = 3'(occ) + 3'(if_valid);
    assign issue       = (state == ST_BURST) && !grant_empty && (credit < 3'd2 + 3'(pop));

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        cnt_nxt      = cnt;
        sof_pend_nxt = sof_pend;
        ch_rd_en     = '0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt    = pick_idx;
                    cnt_nxt      = '0;
                    sof_pend_nxt = 1'b1;
                    state_nxt    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (issue) begin
                    ch_rd_en[grant] = 1'b1;
                    cnt_nxt         = cnt + 1'b1;
                    sof_pend_nxt    = 1'b0;
                    if (cnt == CNT_W'(BURST - 1)) state_nxt = ST_IDLE;
                end
                if (grant_empty) state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= CH_W'(NUM_CH - 1);
            cnt      <= '0;
            sof_pend <= 1'b0;
            if_valid <= 1'b0;
            if_ch    <= '0;
            if_sof   <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            cnt      <= cnt_nxt;
            sof_pend <= sof_pend_nxt;
            if_valid <= issue;
            if (issue) begin
                if_ch  <= grant;
                if_sof <= sof_pend;
            end
        end
    end

    // Registered FIFO dout of the channel read last cycle.
    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (if_ch == CH_W'(i)) dout_sel = ch_dout[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: the buffer entries are reset because m_data/m_ch/m_sof read them directly and must come up at 0.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= '{data: dout_sel, ch: if_ch, sof: if_sof};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_q[rd_ptr].data;
    assign m_ch    = buf_q[rd_ptr].ch;
    assign m_sof   = buf_q[rd_ptr].sof;
    assign busy    = (state != ST_IDLE) || (occ != 2'd0) || if_valid;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Self-checking bench for fifo_rd_sched: table-driven drain scenarios plus hand-written
// stall and reset sequences, against behavioural FIFOs with registered read data.
module tb_fifo_rd_sched;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int BURST  = 4;
    localparam int CH_W   = 2;
    localparam int DEPTH  = 64;

    logic                    rclk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       ch_enable, ch_empty, ch_rd_en;
    logic [NUM_CH*WIDTH-1:0] ch_dout;
    logic                    m_valid, m_ready, m_sof, busy;
    logic [WIDTH-1:0]        m_data;
    logic [CH_W-1:0]         m_ch;

    always #5 rclk = ~rclk;

    fifo_rd_sched #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .BURST(BURST)) dut (
        .rclk      (rclk),
        .rst_n     (rst_n),
        .ch_enable (ch_enable),
        .ch_empty  (ch_empty),
        .ch_dout   (ch_dout),
        .ch_rd_en  (ch_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .m_sof     (m_sof),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFOs: append-only storage, registered read data, empty from counts.
    logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
    int               n_words [NUM_CH] = '{default: 0};
    int               rd_idx  [NUM_CH] = '{default: 0};
    logic [WIDTH-1:0] dout_r  [NUM_CH] = '{default: '0};
    int               underflow = 0;
    int               cyc = 0;

    function automatic logic [WIDTH-1:0] word(input int c, input int s);
        return {c[1:0], s[5:0]};
    endfunction

    always_comb begin
        ch_empty = '0;
        ch_dout  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i]                = (rd_idx[i] >= n_words[i]);
            ch_dout[i*WIDTH +: WIDTH]  = dout_r[i];
        end
    end

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rd_en[i]) begin
                if (rd_idx[i] < n_words[i]) dout_r[i] <= mem[i][rd_idx[i]];
                else underflow <= underflow + 1;
                rd_idx[i] <= rd_idx[i] + 1;
            end
        end
    end

    // Monitor: accepted words and read strobes, sampled mid-cycle.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
        logic             sof;
        logic [31:0]      cyc;
    } obs_t;

    obs_t out_q[$];
    int   rd_cyc_q[$];
    int   rd_cnt [NUM_CH] = '{default: 0};
    int   multi_rd = 0;

    always @(negedge rclk) begin
        if (rst_n) begin
            if (m_valid && m_ready) out_q.push_back('{m_data, m_ch, m_sof, cyc});
            if (ch_rd_en != '0) begin
                rd_cyc_q.push_back(cyc);
                if ($countones(ch_rd_en) != 1) multi_rd++;
                for (int i = 0; i < NUM_CH; i++) if (ch_rd_en[i]) rd_cnt[i]++;
            end
        end
    end

    task automatic load(input int c, input int n);
        for (int k = 0; k < n; k++) mem[c][n_words[c] + k] = word(c, n_words[c] + k);
        n_words[c] += n;
    endtask

    task automatic reset_dut();
        @(posedge rclk);
        #1 rst_n = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge rclk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_word(input string tag, input int idx, input int c, input int s, input logic sof);
        if (idx < out_q.size()) begin
            check({tag, "_ch"},   32'(out_q[idx].ch),   32'(c));
            check({tag, "_data"}, 32'(out_q[idx].data), 32'(word(c, s)));
            check({tag, "_sof"},  32'(out_q[idx].sof),  32'(sof));
        end
    endtask

    // Scenario table: FIFO fill per channel, enable masks, expected grant sequence (first grant in [7]).
    typedef struct packed {
        logic [NUM_CH-1:0][7:0] words;
        logic [NUM_CH-1:0]      en_init;
        logic [NUM_CH-1:0]      en_sw;
        logic [7:0]             sw_at;    // total reads after which en_sw applies (0 = never)
        logic [3:0]             ng;
        logic [7:0][3:0]        gch;
        logic [7:0][3:0]        glen;
    } vec_t;

    vec_t tbl [4];

    task automatic run_vec(input vec_t v, input int id);
        int    o0, r0, n_exp, k, prev_cyc;
        int    base [NUM_CH];
        int    seq  [NUM_CH];
        int    rc0  [NUM_CH];
        int    exp_rd [NUM_CH];
        bit    sw_done;
        string tag;
        reset_dut();
        o0 = out_q.size();
        r0 = rd_cyc_q.size();
        for (int c = 0; c < NUM_CH; c++) begin
            base[c] = n_words[c];
            seq[c]  = 0;
            rc0[c]  = rd_cnt[c];
            exp_rd[c] = 0;
        end
        n_exp = 0;
        for (int g = 0; g < int'(v.ng); g++) begin
            n_exp += int'(v.glen[7-g]);
            exp_rd[v.gch[7-g]] += int'(v.glen[7-g]);
        end
        for (int c = 0; c < NUM_CH; c++) load(c, int'(v.words[c]));
        ch_enable = v.en_init;
        m_ready   = 1'b1;
        sw_done   = (v.sw_at == 8'd0);
        for (int t = 0; t < 400; t++) begin
            @(posedge rclk);
            #1;
            if (!sw_done && (rd_cyc_q.size() - r0) >= int'(v.sw_at)) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (!v.en_init[c]) check($sformatf("v%0d_masked_rd%0d", id, c), rd_cnt[c] - rc0[c], 0);
                ch_enable = v.en_sw;
                sw_done   = 1'b1;
            end
            if ((out_q.size() - o0) >= n_exp && !busy) break;
        end
        check($sformatf("v%0d_count", id), out_q.size() - o0, n_exp);
        check($sformatf("v%0d_busy_end", id), busy, 1'b0);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("v%0d_rd_cnt%0d", id, c), rd_cnt[c] - rc0[c], exp_rd[c]);
        k = 0;
        prev_cyc = 0;
        for (int g = 0; g < int'(v.ng); g++) begin
            for (int j = 0; j < int'(v.glen[7-g]); j++) begin
                tag = $sformatf("v%0d_w%0d", id, k);
                check_word(tag, o0 + k, int'(v.gch[7-g]), base[v.gch[7-g]] + seq[v.gch[7-g]], j == 0);
                seq[v.gch[7-g]]++;
                if (o0 + k < out_q.size() && r0 + k < rd_cyc_q.size()) begin
                    check({tag, "_lat"}, int'(out_q[o0+k].cyc) - rd_cyc_q[r0+k], 2);
                    if (k > 0) check({tag, "_gap"}, int'(out_q[o0+k].cyc) - prev_cyc, (j == 0) ? 2 : 1);
                    prev_cyc = int'(out_q[o0+k].cyc);
                end
                k++;
            end
        end
    endtask

    initial begin
        int   o0, rc, base1, base3, stall_bad, lat;
        bit   seen;
        logic [WIDTH-1:0] exp_w;

        tbl[0] = '{words: {8'd0, 8'd0, 8'd0, 8'd3}, en_init: 4'hF, en_sw: 4'hF, sw_at: 8'd0,
                   ng: 4'd1, gch: 32'h0000_0000, glen: 32'h3000_0000};
        tbl[1] = '{words: {8'd8, 8'd8, 8'd8, 8'd8}, en_init: 4'hF, en_sw: 4'hF, sw_at: 8'd0,
                   ng: 4'd8, gch: 32'h0123_0123, glen: 32'h4444_4444};
        tbl[2] = '{words: {8'd8, 8'd8, 8'd8, 8'd8}, en_init: 4'b1010, en_sw: 4'hF, sw_at: 8'd9,
                   ng: 4'd8, gch: 32'h1312_3020, glen: 32'h4444_4444};
        tbl[3] = '{words: {8'd0, 8'd0, 8'd16, 8'd0}, en_init: 4'hF, en_sw: 4'hF, sw_at: 8'd0,
                   ng: 4'd4, gch: 32'h1111_0000, glen: 32'h4444_0000};

        rst_n     = 1'b0;
        ch_enable = '0;
        m_ready   = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        check("rst_m_valid",  m_valid,  1'b0);
        check("rst_m_data",   m_data,   8'h00);
        check("rst_m_ch",     m_ch,     2'd0);
        check("rst_m_sof",    m_sof,    1'b0);
        check("rst_ch_rd_en", ch_rd_en, 4'h0);
        check("rst_busy",     busy,     1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(tbl[i], i);

        // Back-pressure: ch2 with 4 words, consumer stalled.
        reset_dut();
        ch_enable = 4'hF;
        m_ready   = 1'b0;
        o0    = out_q.size();
        rc    = rd_cnt[2];
        exp_w = word(2, n_words[2]);
        base1 = n_words[2];
        load(2, 4);
        for (int t = 0; t < 20; t++) begin
            @(posedge rclk);
            #1;
            if (rd_cnt[2] != rc) break;
        end
        check("stall_first_rd", rd_cnt[2] - rc, 1);
        stall_bad = 0;
        seen      = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge rclk);
            #1;
            if (m_valid) begin
                if (m_data !== exp_w || m_ch !== 2'd2 || m_sof !== 1'b1) stall_bad++;
                seen = 1'b1;
            end else if (seen) begin
                stall_bad++;
            end
        end
        check("stall_rd_count", rd_cnt[2] - rc, 2);
        check("stall_seen",     seen, 1'b1);
        check("stall_stable",   stall_bad, 0);
        m_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(posedge rclk);
            #1;
            if ((out_q.size() - o0) >= 4 && !busy) break;
        end
        check("stall_count", out_q.size() - o0, 4);
        for (int j = 0; j < 4; j++) check_word($sformatf("stall_w%0d", j), o0 + j, 2, base1 + j, j == 0);

        // Asynchronous reset with the output buffer full, then re-arbitration from ch0.
        reset_dut();
        ch_enable = 4'hF;
        m_ready   = 1'b0;
        base1 = n_words[1];
        base3 = n_words[3];
        load(1, 4);
        load(3, 4);
        for (int t = 0; t < 20; t++) begin
            @(posedge rclk);
            #1;
            if (m_valid) break;
        end
        @(posedge rclk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_m_valid",  m_valid,  1'b0);
        check("arst_m_data",   m_data,   8'h00);
        check("arst_m_ch",     m_ch,     2'd0);
        check("arst_m_sof",    m_sof,    1'b0);
        check("arst_ch_rd_en", ch_rd_en, 4'h0);
        check("arst_busy",     busy,     1'b0);
        o0 = out_q.size();
        repeat (2) @(posedge rclk);
        #1;
        m_ready = 1'b1;
        rst_n   = 1'b1;
        lat = 0;
        for (int t = 1; t <= 10; t++) begin
            @(posedge rclk);
            #1;
            if (m_valid) begin
                lat = t;
                break;
            end
        end
        check("arst_first_valid_lat", lat, 3);
        for (int t = 0; t < 60; t++) begin
            @(posedge rclk);
            #1;
            if ((out_q.size() - o0) >= 6 && !busy) break;
        end
        check("arst_count", out_q.size() - o0, 6);
        check_word("arst_w0", o0 + 0, 1, base1 + 2, 1'b1);
        check_word("arst_w1", o0 + 1, 1, base1 + 3, 1'b0);
        for (int j = 0; j < 4; j++) check_word($sformatf("arst_w%0d", j + 2), o0 + 2 + j, 3, base3 + j, j == 0);

        check("fifo_underflow", underflow, 0);
        check("rd_en_onehot",   multi_rd,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
